uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 13 +
 rtl/rr_picker.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and constants for the UART transmit arbiter.
// Used by uart_tx_arbiter (optional feature macro: UART_ARB_LOCK_EN).
package uart_pkg;
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } uart_arb_state_t;

  localparam int ARB_START_TIMEOUT = 4;
  localparam int ARB_TO_W = $clog2(ARB_START_TIMEOUT) + 1;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin winner search.
// Scans upward from last+1 with wrap-around; valid when any request is set.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last,
  output logic               valid,
  output logic [IDW-1:0]     idx
);
  logic [IDW-1:0] cand;

  // Farthest candidate first so the nearest one overwrites it.
  always_comb begin
    cand = '0;
    idx  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDW'((int'(last) + k) % NUM_REQ);
      if (req[cand]) idx = cand;
    end
  end

  assign valid = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter handing bytes to one UART transmitter.
// Define UART_ARB_LOCK_EN to add the lock input for multi-byte packets.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready
`ifdef UART_ARB_LOCK_EN
  ,
  input  logic [NUM_REQ-1:0]   lock
`endif
);
  localparam logic [IDW-1:0] LastRst = IDW'(NUM_REQ - 1);
  localparam logic [ARB_TO_W-1:0] ToLast =
    ARB_TO_W'(ARB_START_TIMEOUT - 1);

  uart_arb_state_t     state_q, state_d;
  logic [7:0]          data_q, data_d;
  logic [IDW-1:0]      grant_q, grant_d;
  logic [IDW-1:0]      last_q, last_d;
  logic [ARB_TO_W-1:0] cnt_q, cnt_d;
  logic [IDW-1:0]      pick_idx, win_idx;
  logic [IDW+2:0]      base;
  logic                pick_vld, win_vld, hold, fire;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req   (req),
    .last  (last_q),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

`ifdef UART_ARB_LOCK_EN
  assign hold = lock[grant_q] & req[grant_q];
`else
  assign hold = 1'b0;
`endif

  assign win_idx = hold ? grant_q : pick_idx;
  assign win_vld = hold | pick_vld;
  assign base    = {win_idx, 3'b000};

  // cnt_q counts cycles since the last tx_start while waiting for busy.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tx_ready && win_vld) begin
          fire    = 1'b1;
          data_d  = req_data[base +: 8];
          grant_d = win_idx;
          last_d  = win_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = ARB_TO_W'(1);
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!tx_ready) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (cnt_q == ToLast) begin
          cnt_d   = '0;
          state_d = ISSUE;
        end else begin
          cnt_d = cnt_q + ARB_TO_W'(1);
        end
      end
      WAIT_DONE: begin
        if (tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      grant_q <= '0;
      last_q  <= LastRst;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // ack is decided in IDLE, so it is masked while reset is held.
  assign ack      = (fire && reset_n) ?
                    (NUM_REQ'(1) << win_idx) : '0;
  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);
  assign tx_start = (state_q == ISSUE);
  assign tx_data  = data_q;
endmodule
